// File: rtl/data_mem_scp_pkg.sv
// Shared encodings and helpers for the single-cycle data memory stage.
package data_mem_scp_pkg;

  // MemSize encodings; 2'b11 is the illegal size.
  localparam logic [1:0] MS_BYTE = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_WORD = 2'b10;

  // Word-index width for a memory of the given depth (at least 1 bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_scp_lane_align.sv
// Big-endian byte-lane handling: load lane select and extension, and
// store byte-enable generation and data replication.
module mem_lane_align
  import data_mem_scp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Load path: pick the addressed lane (lane 0 is the MSB) and extend it.
  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    ld_data  = 32'h0;
    case (lane)
      2'b00:   sel_byte = rd_word[31:24];
      2'b01:   sel_byte = rd_word[23:16];
      2'b10:   sel_byte = rd_word[15:8];
      default: sel_byte = rd_word[7:0];
    endcase
    sel_half = lane[1] ? rd_word[15:0] : rd_word[31:16];
    case (size)
      MS_BYTE: ld_data = sign_ext ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      MS_HALF: ld_data = sign_ext ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
      MS_WORD: ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
  end

  // Store path: byte_en[i] covers bits 8i+7:8i; data is replicated so any lane sees it.
  always_comb begin
    byte_en = 4'b0000;
    st_word = wr_data;
    case (size)
      MS_BYTE: begin
        byte_en = 4'b1000 >> lane;
        st_word = {4{wr_data[7:0]}};
      end
      MS_HALF: begin
        byte_en = lane[1] ? 4'b0011 : 4'b1100;
        st_word = {2{wr_data[15:0]}};
      end
      MS_WORD: begin
        byte_en = 4'b1111;
        st_word = wr_data;
      end
      default: begin
        byte_en = 4'b0000;
        st_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_scp.sv
// Data memory stage: word-organised big-endian RAM with combinational read,
// synchronous byte-lane write, fault detection and sticky fault status.
module data_mem_scp
  import data_mem_scp_pkg::*;
#(
  parameter int WL    = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    MemSize,
  input  logic          MemSignExt,
  input  logic [WL-1:0] Addr,
  input  logic [WL-1:0] WrData,
  output logic [WL-1:0] RdData,
  output logic          AlignErr,
  output logic          RangeErr,
  output logic          ErrSticky,
  output logic [WL-1:0] ErrAddr,
  output logic [15:0]   StoreCount
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [WL-1:0] ADDR_LIMIT = WL'(4 * DEPTH);

  logic [WL-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [WL-1:0]     rd_word;
  logic [WL-1:0]     ld_data;
  logic [WL-1:0]     st_word;
  logic [3:0]        byte_en;
  logic              fault;
  logic              commit;

  assign word_idx = Addr[ADDR_W+1:2];
  assign rd_word  = mem[word_idx];

  // Fault decode is live every cycle, independent of MemRead/MemWrite.
  always_comb begin
    AlignErr = (MemSize == 2'b11)
             | ((MemSize == MS_HALF) & Addr[0])
             | ((MemSize == MS_WORD) & (Addr[1:0] != 2'b00));
    RangeErr = (Addr >= ADDR_LIMIT);
    fault    = (MemRead | MemWrite) & (AlignErr | RangeErr | (MemRead & MemWrite));
    commit   = MemWrite & ~fault;
    RdData   = (MemRead & ~fault) ? ld_data : '0;
  end

  mem_lane_align u_lane (
    .size     (MemSize),
    .sign_ext (MemSignExt),
    .lane     (Addr[1:0]),
    .rd_word  (rd_word),
    .wr_data  (WrData),
    .ld_data  (ld_data),
    .byte_en  (byte_en),
    .st_word  (st_word)
  );

  // Memory array: cleared on reset, only enabled lanes of a committed store change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  // Status: first fault is latched and held; store counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ErrSticky  <= 1'b0;
      ErrAddr    <= '0;
      StoreCount <= 16'h0;
    end else begin
      if (fault && !ErrSticky) begin
        ErrSticky <= 1'b1;
        ErrAddr   <= Addr;
      end
      if (commit && StoreCount != 16'hFFFF) StoreCount <= StoreCount + 16'h1;
    end
  end

endmodule

// File: tb/tb_data_mem_scp.sv
// Directed bench for data_mem_scp with hand-computed expected values.
module tb_data_mem_scp;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemSignExt;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        AlignErr;
  logic        RangeErr;
  logic        ErrSticky;
  logic [31:0] ErrAddr;
  logic [15:0] StoreCount;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  data_mem_scp #(.WL(32), .DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemSize    (MemSize),
    .MemSignExt (MemSignExt),
    .Addr       (Addr),
    .WrData     (WrData),
    .RdData     (RdData),
    .AlignErr   (AlignErr),
    .RangeErr   (RangeErr),
    .ErrSticky  (ErrSticky),
    .ErrAddr    (ErrAddr),
    .StoreCount (StoreCount)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Driver tasks: apply settles combinational outputs, step crosses one edge.
  task automatic apply(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemSignExt = sx; Addr = a; WrData = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    apply(1'b1, 1'b0, sz, sx, a, 32'h0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    apply(1'b0, 1'b1, sz, 1'b0, a, d);
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    check("rst_sticky", {31'h0, ErrSticky}, 32'h0);
    check("rst_erraddr", ErrAddr, 32'h0);
    check("rst_count", {16'h0, StoreCount}, 32'h0);

    // 1: reset pulse during a store to word 3 drops it
    apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    load(2'b10, 1'b0, 32'h0C); check("t1_lw_0c", RdData, 32'h0);
    load(2'b10, 1'b0, 32'hFC); check("t1_lw_fc", RdData, 32'h0);
    check("t1_range_fc", {31'h0, RangeErr}, 32'h0);
    check("t1_count", {16'h0, StoreCount}, 32'h0);

    // 2: word store then big-endian sub-word loads, via the expected queue
    store(2'b10, 32'h08, 32'h12345678);
    check("t2_count", {16'h0, StoreCount}, 32'h1);
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h00005678);
    exp_q.push_back(32'h00000034);
    exp_q.push_back(32'h00001234);
    exp_q.push_back(32'h00000012);
    load(2'b10, 1'b0, 32'h08); check("t2_lw_08", RdData, exp_q.pop_front());
    load(2'b01, 1'b0, 32'h0A); check("t2_lhu_0a", RdData, exp_q.pop_front());
    load(2'b00, 1'b1, 32'h09); check("t2_lb_09", RdData, exp_q.pop_front());
    load(2'b01, 1'b1, 32'h08); check("t2_lh_08", RdData, exp_q.pop_front());
    load(2'b00, 1'b0, 32'h08); check("t2_lbu_08", RdData, exp_q.pop_front());

    // 3: byte store merges into one lane; half store into upper half
    store(2'b00, 32'h0B, 32'h000000FF);
    load(2'b10, 1'b0, 32'h08); check("t3_lw_08", RdData, 32'h123456FF);
    load(2'b00, 1'b1, 32'h0B); check("t3_lb_0b", RdData, 32'hFFFFFFFF);
    load(2'b00, 1'b0, 32'h0B); check("t3_lbu_0b", RdData, 32'h000000FF);
    store(2'b01, 32'h08, 32'hABCD8001);
    load(2'b10, 1'b0, 32'h08); check("t3_lw_after_sh", RdData, 32'h800156FF);
    load(2'b01, 1'b1, 32'h08); check("t3_lh_08", RdData, 32'hFFFF8001);
    check("t3_count", {16'h0, StoreCount}, 32'h3);
    check("t3_sticky", {31'h0, ErrSticky}, 32'h0);

    // 4: misaligned load latches first fault; later fault does not overwrite
    load(2'b10, 1'b0, 32'h06);
    check("t4_align", {31'h0, AlignErr}, 32'h1);
    check("t4_rd", RdData, 32'h0);
    step();
    check("t4_sticky", {31'h0, ErrSticky}, 32'h1);
    check("t4_erraddr", ErrAddr, 32'h6);
    apply(1'b0, 1'b1, 2'b01, 1'b0, 32'h101, 32'h0000BEEF);
    check("t4_sh_align", {31'h0, AlignErr}, 32'h1);
    check("t4_sh_range", {31'h0, RangeErr}, 32'h1);
    step();
    idle();
    check("t4_erraddr_held", ErrAddr, 32'h6);
    check("t4_count", {16'h0, StoreCount}, 32'h3);

    // 5: out-of-range store dropped, no aliasing to word 0; boundary and idle decode
    apply(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hAAAA5555);
    check("t5_range", {31'h0, RangeErr}, 32'h1);
    check("t5_align", {31'h0, AlignErr}, 32'h0);
    step();
    idle();
    check("t5_count", {16'h0, StoreCount}, 32'h3);
    load(2'b10, 1'b0, 32'h00); check("t5_lw_00", RdData, 32'h0);
    load(2'b00, 1'b0, 32'hFF); check("t5_range_ff", {31'h0, RangeErr}, 32'h0);
    apply(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    check("t5_idle_align", {31'h0, AlignErr}, 32'h1);
    apply(1'b0, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
    check("t5_idle_range", {31'h0, RangeErr}, 32'h1);
    apply(1'b0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    check("t5_size11", {31'h0, AlignErr}, 32'h1);

    // 6: read+write together is illegal; plain store then commits
    apply(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("t6_rw_rd", RdData, 32'h0);
    step();
    check("t6_rw_count", {16'h0, StoreCount}, 32'h3);
    step();
    check("t6_rw2_count", {16'h0, StoreCount}, 32'h3);
    load(2'b10, 1'b0, 32'h10); check("t6_lw_old", RdData, 32'h0);
    store(2'b10, 32'h10, 32'hDEADBEEF);
    check("t6_count", {16'h0, StoreCount}, 32'h4);
    load(2'b10, 1'b0, 32'h10); check("t6_lw_new", RdData, 32'hDEADBEEF);
    check("t6_erraddr", ErrAddr, 32'h6);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
